// File: rtl/az_sample_collector.sv
// -----------------------------------------------------------------------------
// az_sample_collector
//
// Receive-side companion to the AZ modulation sequencer. The sequencer's
// precharge switch state and AZ mux select are decoded into HI (signal) and
// LO (zero) sample windows. ADC results that arrive inside each window are
// summed. Every HI window that is followed by a LO window produces one record:
// both sums, both sample counts and the AZ-corrected difference hi_sum - lo_sum.
//
// Ports
//   clk           system clock (20 MHz)
//   reset         asynchronous, active-high
//   sw_pc_ctl     precharge switch state (1 = signal, 0 = boot)
//   mux_az        AZ mux select
//   adc_valid     one-cycle strobe, adc_data valid
//   adc_data      signed conversion result, DATA_W bits
//   clear_err     clears the sticky error flags on the next edge
//   result_valid  one-cycle strobe, record outputs updated
//   hi_sum        signed sum of HI-window samples
//   lo_sum        signed sum of LO-window samples
//   hi_count      samples in the HI window
//   lo_count      samples in the LO window
//   diff          signed hi_sum - lo_sum (one bit wider than the sums)
//   err_timeout   sticky: a window lasted TIMEOUT_N clocks
//   err_ovf       sticky: a sample counter was saturated and a sample dropped
//   err_seq       sticky: HI re-entered before any LO window
//   state_mon     current FSM state code
// -----------------------------------------------------------------------------
module az_sample_collector #(
  parameter int         DATA_W      = 24,
  parameter int         CNT_W       = 8,
  parameter logic [2:0] MUX_LO_CODE = 3'd7,
  parameter logic [2:0] MUX_HI_CODE = 3'd0,
  parameter int         TIMEOUT_N   = 2000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sw_pc_ctl,
  input  logic [2:0]                mux_az,
  input  logic                      adc_valid,
  input  logic [DATA_W-1:0]         adc_data,
  input  logic                      clear_err,
  output logic                      result_valid,
  output logic [DATA_W+CNT_W-1:0]   hi_sum,
  output logic [DATA_W+CNT_W-1:0]   lo_sum,
  output logic [CNT_W-1:0]          hi_count,
  output logic [CNT_W-1:0]          lo_count,
  output logic [DATA_W+CNT_W:0]     diff,
  output logic                      err_timeout,
  output logic                      err_ovf,
  output logic                      err_seq,
  output logic [2:0]                state_mon
);

  localparam int SUM_W = DATA_W + CNT_W;
  localparam int TMR_W = $clog2(TIMEOUT_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_N - 1);

  typedef enum logic [2:0] {
    ST_ARM     = 3'd0,
    ST_SEEK    = 3'd1,
    ST_HI_ACC  = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_LO_ACC  = 3'd4,
    ST_EMIT    = 3'd5
  } state_t;

  // Input stage
  logic              sw_pc_ctl_q;
  logic [2:0]        mux_az_q;
  logic              adc_valid_q;
  logic [DATA_W-1:0] adc_data_q;
  // Set one edge after reset: the input registers then hold real sequencer
  // state rather than their reset zeros, so ARM can trust the decode.
  logic              primed_q;

  // FSM, timer and running accumulators
  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [SUM_W-1:0]  hi_acc_q, hi_acc_d;
  logic [SUM_W-1:0]  lo_acc_q, lo_acc_d;
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  lo_cnt_q, lo_cnt_d;

  // Record registers
  logic [SUM_W-1:0]  rec_hi_sum_q, rec_hi_sum_d;
  logic [SUM_W-1:0]  rec_lo_sum_q, rec_lo_sum_d;
  logic [CNT_W-1:0]  rec_hi_cnt_q, rec_hi_cnt_d;
  logic [CNT_W-1:0]  rec_lo_cnt_q, rec_lo_cnt_d;
  logic [SUM_W:0]    rec_diff_q,   rec_diff_d;

  // Sticky errors
  logic              err_timeout_q, err_timeout_d;
  logic              err_ovf_q,     err_ovf_d;
  logic              err_seq_q,     err_seq_d;
  logic              set_timeout, set_ovf, set_seq;

  logic              is_hi, is_lo;
  logic [SUM_W-1:0]  sample_ext;

  assign is_hi      = sw_pc_ctl_q  && (mux_az_q == MUX_HI_CODE);
  assign is_lo      = !sw_pc_ctl_q && (mux_az_q == MUX_LO_CODE);
  assign sample_ext = {{CNT_W{adc_data_q[DATA_W-1]}}, adc_data_q};

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hi_acc_d     = hi_acc_q;
    lo_acc_d     = lo_acc_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    rec_hi_sum_d = rec_hi_sum_q;
    rec_lo_sum_d = rec_lo_sum_q;
    rec_hi_cnt_d = rec_hi_cnt_q;
    rec_lo_cnt_d = rec_lo_cnt_q;
    rec_diff_d   = rec_diff_q;
    set_timeout  = 1'b0;
    set_ovf      = 1'b0;
    set_seq      = 1'b0;

    case (state_q)
      ST_ARM: begin
        // Never start inside a HI window that was already running.
        if (primed_q && !is_hi) state_d = ST_SEEK;
      end

      ST_SEEK: begin
        if (is_hi) begin
          hi_acc_d = '0;
          lo_acc_d = '0;
          hi_cnt_d = '0;
          lo_cnt_d = '0;
          timer_d  = '0;
          state_d  = ST_HI_ACC;
        end
      end

      ST_HI_ACC: begin
        if (timer_q == TMR_LAST) begin
          set_timeout = 1'b1;
          state_d     = ST_ARM;
        end else if (!is_hi) begin
          timer_d = '0;
          state_d = ST_WAIT_LO;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (adc_valid_q) begin
            if (hi_cnt_q == CNT_MAX) begin
              set_ovf = 1'b1;
            end else begin
              hi_acc_d = hi_acc_q + sample_ext;
              hi_cnt_d = hi_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ST_WAIT_LO: begin
        if (timer_q == TMR_LAST) begin
          set_timeout = 1'b1;
          state_d     = ST_ARM;
        end else if (is_lo) begin
          timer_d = '0;
          state_d = ST_LO_ACC;
        end else if (is_hi) begin
          // A second HI before any LO: the first HI window is discarded.
          set_seq  = 1'b1;
          hi_acc_d = '0;
          hi_cnt_d = '0;
          timer_d  = '0;
          state_d  = ST_HI_ACC;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_LO_ACC: begin
        if (timer_q == TMR_LAST) begin
          set_timeout = 1'b1;
          state_d     = ST_ARM;
        end else if (!is_lo) begin
          // Accumulators are final here (no sample is taken outside LO), so
          // the record is loaded now and is already visible in EMIT.
          rec_hi_sum_d = hi_acc_q;
          rec_lo_sum_d = lo_acc_q;
          rec_hi_cnt_d = hi_cnt_q;
          rec_lo_cnt_d = lo_cnt_q;
          rec_diff_d   = {hi_acc_q[SUM_W-1], hi_acc_q} - {lo_acc_q[SUM_W-1], lo_acc_q};
          state_d      = ST_EMIT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (adc_valid_q) begin
            if (lo_cnt_q == CNT_MAX) begin
              set_ovf = 1'b1;
            end else begin
              lo_acc_d = lo_acc_q + sample_ext;
              lo_cnt_d = lo_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ST_EMIT: begin
        if (is_hi) begin
          hi_acc_d = '0;
          lo_acc_d = '0;
          hi_cnt_d = '0;
          lo_cnt_d = '0;
          timer_d  = '0;
          state_d  = ST_HI_ACC;
        end else begin
          state_d = ST_SEEK;
        end
      end

      default: state_d = ST_ARM;
    endcase
  end

  // A set event in the same cycle as clear_err wins.
  assign err_timeout_d = (err_timeout_q && !clear_err) || set_timeout;
  assign err_ovf_d     = (err_ovf_q     && !clear_err) || set_ovf;
  assign err_seq_d     = (err_seq_q     && !clear_err) || set_seq;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // Every register, including the record outputs, is reset so that a reset
  // mid-operation returns all outputs to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_pc_ctl_q   <= 1'b0;
      mux_az_q      <= '0;
      adc_valid_q   <= 1'b0;
      adc_data_q    <= '0;
      primed_q      <= 1'b0;
      state_q       <= ST_ARM;
      timer_q       <= '0;
      hi_acc_q      <= '0;
      lo_acc_q      <= '0;
      hi_cnt_q      <= '0;
      lo_cnt_q      <= '0;
      rec_hi_sum_q  <= '0;
      rec_lo_sum_q  <= '0;
      rec_hi_cnt_q  <= '0;
      rec_lo_cnt_q  <= '0;
      rec_diff_q    <= '0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_seq_q     <= 1'b0;
    end else begin
      sw_pc_ctl_q   <= sw_pc_ctl;
      mux_az_q      <= mux_az;
      adc_valid_q   <= adc_valid;
      adc_data_q    <= adc_data;
      primed_q      <= 1'b1;
      state_q       <= state_d;
      timer_q       <= timer_d;
      hi_acc_q      <= hi_acc_d;
      lo_acc_q      <= lo_acc_d;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      rec_hi_sum_q  <= rec_hi_sum_d;
      rec_lo_sum_q  <= rec_lo_sum_d;
      rec_hi_cnt_q  <= rec_hi_cnt_d;
      rec_lo_cnt_q  <= rec_lo_cnt_d;
      rec_diff_q    <= rec_diff_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
      err_seq_q     <= err_seq_d;
    end
  end

  assign result_valid = (state_q == ST_EMIT);
  assign hi_sum       = rec_hi_sum_q;
  assign lo_sum       = rec_lo_sum_q;
  assign hi_count     = rec_hi_cnt_q;
  assign lo_count     = rec_lo_cnt_q;
  assign diff         = rec_diff_q;
  assign err_timeout  = err_timeout_q;
  assign err_ovf      = err_ovf_q;
  assign err_seq      = err_seq_q;
  assign state_mon    = state_q;

endmodule
